// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the issue scheduler: register-index width, the x0
// constant and the scoreboard entry layout.
package hazard_sched_pkg;

    // Default register index width (32 architectural registers).
    localparam int REG_W_DEF = 5;

    // Architectural x0: hard-wired zero, never a hazard source or target.
    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

    // One in-flight register write: valid flag plus destination index.
    typedef struct packed {
        logic                 v;
        logic [REG_W_DEF-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_sched_sb_match.sv
// Combinational lookup of one source register against every scoreboard
// entry. A hit means the source still has an uncommitted write in flight.
module sb_match
    import hazard_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic [REG_W_DEF-1:0]   src,
    input  logic                   used,
    input  sb_entry_t [DEPTH-1:0]  entries,
    output logic                   hit
);

    // Any valid entry with a matching rd is a hit; x0 and unused sources never hit.
    always_comb begin
        hit = 1'b0;
        if (used && (src != REG_ZERO)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].v && (entries[i].rd == src)) begin
                    hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Issue scheduler for the single-issue datapath. Holds the decoded
// instruction while any source register has a write still in the
// DEPTH-stage scoreboard, drives PC enable / issue / bubble, counts stall
// cycles and lets a branch-redirect flush kill the decode instruction.
// All decisions are combinational on the current cycle's inputs and state.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [REG_W-1:0] rs1,
    input  logic             rs1_used,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd,
    input  logic             reg_write,
    input  logic             flush,
    output logic             pc_en,
    output logic             issue,
    output logic             bubble,
    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // sb[0] is the most recent issue; sb[DEPTH-1] commits on the next edge.
    // The register file has no write-through, so every valid entry blocks.
    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             sb_in;

    logic hz1;
    logic hz2;
    logic hz;

    sb_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .src     (rs1),
        .used    (rs1_used),
        .entries (sb),
        .hit     (hz1)
    );

    sb_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .src     (rs2),
        .used    (rs2_used),
        .entries (sb),
        .hit     (hz2)
    );

    assign hz = hz1 | hz2;

    // Issue control: flush beats a hazard, reset forces a closed pipe.
    always_comb begin
        stall  = inst_valid & hz & ~flush & ~rst;
        issue  = inst_valid & ~hz & ~flush & ~rst;
        bubble = ~issue;
        pc_en  = ~rst & (flush | ~stall);
    end

    // New scoreboard entry: only issued instructions that really write a non-x0 rd.
    always_comb begin
        sb_in.v  = issue & reg_write & (rd != REG_ZERO);
        sb_in.rd = rd;
    end

    // Busy whenever any write is still in flight.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | sb[i].v;
        end
    end

    // Scoreboard shift register; the oldest entry drops off as it commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb[i] <= sb[i-1];
            end
            sb[0] <= sb_in;
        end
    end

    // Stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios followed by random traffic,
// all checked each cycle against a per-register "ready time" model.
module tb_hazard_sched;

    localparam int DEPTH = 2;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             inst_valid;
    logic [REG_W-1:0] rs1;
    logic             rs1_used;
    logic [REG_W-1:0] rs2;
    logic             rs2_used;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             flush;
    logic             pc_en;
    logic             issue;
    logic             bubble;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_sched #(.DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .rs1        (rs1),
        .rs1_used   (rs1_used),
        .rs2        (rs2),
        .rs2_used   (rs2_used),
        .rd         (rd),
        .reg_write  (reg_write),
        .flush      (flush),
        .pc_en      (pc_en),
        .issue      (issue),
        .bubble     (bubble),
        .stall      (stall),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a register written by an instruction issued in cycle t is
    // unreadable through cycle t+DEPTH; ready_at holds the first readable cycle.
    int  cyc;
    int  ready_at [32];
    int  busy_until;
    int  m_cnt;
    bit  first_step;

    int  n_checks;
    int  n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        busy_until = 0;
        m_cnt      = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic v, input logic [REG_W-1:0] a, input logic au,
                        input logic [REG_W-1:0] b, input logic bu,
                        input logic [REG_W-1:0] d, input logic w,
                        input logic fl, input logic rs);
        bit hz, e_stall, e_issue, e_pc, e_busy;
        inst_valid = v; rs1 = a; rs1_used = au; rs2 = b; rs2_used = bu;
        rd = d; reg_write = w; flush = fl; rst = rs;
        #3;
        hz = (au && a != 0 && cyc < ready_at[a]) || (bu && b != 0 && cyc < ready_at[b]);
        e_stall = v && hz && !fl && !rs;
        e_issue = v && !hz && !fl && !rs;
        e_pc    = !rs && (fl || !e_stall);
        e_busy  = cyc < busy_until;
        check("stall",  {31'b0, stall},  {31'b0, e_stall});
        check("issue",  {31'b0, issue},  {31'b0, e_issue});
        check("bubble", {31'b0, bubble}, {31'b0, !e_issue});
        check("pc_en",  {31'b0, pc_en},  {31'b0, e_pc});
        if (!first_step) begin
            check("busy",      {31'b0, busy},     {31'b0, e_busy});
            check("stall_cnt", {28'b0, stall_cnt}, m_cnt);
        end
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            if (e_stall && m_cnt < CNT_MAX) m_cnt++;
            if (e_issue && w && d != 0) begin
                ready_at[d] = cyc + DEPTH + 1;
                if (cyc + DEPTH + 1 > busy_until) busy_until = cyc + DEPTH + 1;
            end
        end
        cyc++;
        first_step = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 1; first_step = 1'b1;
        model_reset();

        // Power-on reset
        do_reset();
        do_reset();
        check("reset_cnt", {28'b0, stall_cnt}, 0);
        check("reset_busy", {31'b0, busy}, 0);

        // Independent stream: add x5, then add x6 reading x1/x2
        step(1, 1, 1, 2, 1, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 2, 1, 6, 1, 0, 0);
        check("indep_cnt", {28'b0, stall_cnt}, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RAW distance 1: two stall cycles then issue
        do_reset();
        step(1, 1, 1, 2, 1, 5, 1, 0, 0);
        step(1, 5, 1, 0, 0, 7, 1, 0, 0);
        step(1, 5, 1, 0, 0, 7, 1, 0, 0);
        step(1, 5, 1, 0, 0, 7, 1, 0, 0);
        check("raw_cnt", {28'b0, stall_cnt}, 2);

        // x0 write/read and unused source
        do_reset();
        step(1, 1, 1, 2, 1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1, 3, 1, 0, 0);
        check("x0_busy", {31'b0, busy}, 1);
        step(1, 1, 1, 2, 1, 7, 1, 0, 0);
        step(1, 1, 1, 7, 0, 8, 1, 0, 0);
        check("unused_cnt", {28'b0, stall_cnt}, 0);

        // Flush during stall: x5 stays pending until it drains
        do_reset();
        step(1, 1, 1, 2, 1, 5, 1, 0, 0);
        step(1, 5, 1, 0, 0, 9, 1, 1, 0);
        check("flush_busy", {31'b0, busy}, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_busy", {31'b0, busy}, 0);

        // Reset mid-stall: the same instruction issues right after
        do_reset();
        step(1, 1, 1, 2, 1, 9, 1, 0, 0);
        step(1, 9, 1, 0, 0, 4, 1, 0, 0);
        step(1, 9, 1, 0, 0, 4, 1, 0, 1);
        check("rst_mid_cnt", {28'b0, stall_cnt}, 0);
        step(1, 9, 1, 0, 0, 4, 1, 0, 0);

        // Saturation: self-dependent x5 chain, 2 stalls every 3 cycles
        do_reset();
        for (int i = 0; i < 30; i++) step(1, 5, 1, 0, 0, 5, 1, 0, 0);
        check("sat_cnt", {28'b0, stall_cnt}, CNT_MAX);

        // Random traffic over a small register range to force collisions
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 REG_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 REG_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 REG_W'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
